// File: rtl/clock_pkg.sv
// Shared types and helpers for the clock core: two-digit BCD fields, limits,
// BCD increment with wrap and the 24h -> 12h display mapping.
package clock_pkg;

    localparam int DIGIT_W = 4;
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;
    localparam int HR_MAX  = 23;

    typedef struct packed {
        logic [DIGIT_W-1:0] tens;
        logic [DIGIT_W-1:0] ones;
    } bcd2_t;

    function automatic bcd2_t to_bcd2(input int unsigned v);
        bcd2_t r;
        r.tens = DIGIT_W'(v / 10);
        r.ones = DIGIT_W'(v % 10);
        return r;
    endfunction

    // Increment a two-digit BCD value, wrapping to 00 after max_val.
    function automatic bcd2_t bcd_inc(input bcd2_t v, input int unsigned max_val);
        bcd2_t r;
        if (v == to_bcd2(max_val)) begin
            r = '0;
        end else if (v.ones == DIGIT_W'(9)) begin
            r.tens = v.tens + DIGIT_W'(1);
            r.ones = '0;
        end else begin
            r.tens = v.tens;
            r.ones = v.ones + DIGIT_W'(1);
        end
        return r;
    endfunction

    function automatic logic is_pm(input bcd2_t hh);
        return (hh.tens > DIGIT_W'(1)) || (hh.tens == DIGIT_W'(1) && hh.ones >= DIGIT_W'(2));
    endfunction

    // 00 -> 12, 01..12 unchanged, 13..23 -> 01..11.
    function automatic bcd2_t map_12h(input bcd2_t hh);
        int unsigned b;
        b = 32'(hh.tens) * 10 + 32'(hh.ones);
        if (b == 0) begin
            b = 12;
        end else if (b > 12) begin
            b = b - 12;
        end
        return to_bcd2(b);
    endfunction

endpackage

// File: rtl/clock_time_core_button.sv
// Button conditioner: two-flop synchroniser, symmetric debounce and
// hold-to-repeat, producing one-cycle event strobes.
module button_conditioner #(
    parameter int DB         = 1_000_000,
    parameter int RPT_DELAY  = 50_000_000,
    parameter int RPT_PERIOD = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic strobe
);

    localparam int DB_W  = $clog2(DB + 1);
    localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int RPT_W = $clog2(RPT_MAX + 1);

    logic [1:0]       sync;
    logic             pressed;
    logic [DB_W-1:0]  db_cnt;
    logic [RPT_W-1:0] rpt_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync    <= '0;
            pressed <= 1'b0;
            db_cnt  <= DB_W'(DB - 1);
            rpt_cnt <= RPT_W'(RPT_DELAY - 1);
            strobe  <= 1'b0;
        end else begin
            sync   <= {sync[0], btn};
            strobe <= 1'b0;

            if (sync[1] == pressed) begin
                db_cnt <= DB_W'(DB - 1);
            end else if (db_cnt == '0) begin
                pressed <= sync[1];
                db_cnt  <= DB_W'(DB - 1);
                if (sync[1]) begin
                    strobe  <= 1'b1;
                    rpt_cnt <= RPT_W'(RPT_DELAY - 1);
                end
            end else begin
                db_cnt <= db_cnt - DB_W'(1);
            end

            // Repeat only while the pin is still seen high, so a release
            // in progress never produces a late extra event.
            if (pressed && sync[1]) begin
                if (rpt_cnt == '0) begin
                    strobe  <= 1'b1;
                    rpt_cnt <= RPT_W'(RPT_PERIOD - 1);
                end else begin
                    rpt_cnt <= rpt_cnt - RPT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/clock_time_core.sv
// Timekeeping core: 1 Hz prescaler, 24h BCD hh:mm:ss chain, 12h display
// mapping, colon blink and button-driven minute/hour setting.
module clock_time_core
    import clock_pkg::*;
#(
    parameter int TICK_CYCLES       = 100_000_000,
    parameter int DB_CYCLES         = 1_000_000,
    parameter int RPT_DELAY_CYCLES  = 50_000_000,
    parameter int RPT_PERIOD_CYCLES = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_en,
    input  logic       mode_12h,
    input  logic       min_btn,
    input  logic       hr_btn,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic [3:0] hr_ones,
    output logic [3:0] hr_tens,
    output logic       pm,
    output logic       sec_pulse,
    output logic       colon
);

    localparam int PW = $clog2(TICK_CYCLES);

    logic [PW-1:0] presc;
    bcd2_t         ss, mm, hh;
    bcd2_t         hh_step, hh_next, hh_disp;
    logic          min_ev, hr_ev;
    logic          tick, sec_wrap, hr_carry;

    button_conditioner #(
        .DB(DB_CYCLES), .RPT_DELAY(RPT_DELAY_CYCLES), .RPT_PERIOD(RPT_PERIOD_CYCLES)
    ) u_min_btn (
        .clk(clk), .rst(rst), .btn(min_btn), .strobe(min_ev)
    );

    button_conditioner #(
        .DB(DB_CYCLES), .RPT_DELAY(RPT_DELAY_CYCLES), .RPT_PERIOD(RPT_PERIOD_CYCLES)
    ) u_hr_btn (
        .clk(clk), .rst(rst), .btn(hr_btn), .strobe(hr_ev)
    );

    assign tick     = run_en && (presc == PW'(TICK_CYCLES - 1));
    assign sec_wrap = (ss == to_bcd2(SEC_MAX));
    // A minute event discards a coinciding tick, so it cannot carry into hh.
    assign hr_carry = tick && !min_ev && sec_wrap && (mm == to_bcd2(MIN_MAX));

    always_comb begin
        hh_step = hr_carry ? bcd_inc(hh, HR_MAX) : hh;
        hh_next = hr_ev ? bcd_inc(hh_step, HR_MAX) : hh_step;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc     <= '0;
            ss        <= '0;
            mm        <= '0;
            hh        <= '0;
            sec_pulse <= 1'b0;
        end else begin
            sec_pulse <= tick && !min_ev;

            if (min_ev || tick) begin
                presc <= '0;
            end else if (run_en) begin
                presc <= presc + PW'(1);
            end

            if (min_ev) begin
                ss <= '0;
                mm <= bcd_inc(mm, MIN_MAX);
            end else if (tick) begin
                ss <= bcd_inc(ss, SEC_MAX);
                if (sec_wrap) begin
                    mm <= bcd_inc(mm, MIN_MAX);
                end
            end

            hh <= hh_next;
        end
    end

    assign hh_disp  = mode_12h ? map_12h(hh) : hh;
    assign sec_ones = ss.ones;
    assign sec_tens = ss.tens;
    assign min_ones = mm.ones;
    assign min_tens = mm.tens;
    assign hr_ones  = hh_disp.ones;
    assign hr_tens  = hh_disp.tens;
    assign pm       = is_pm(hh);
    assign colon    = !run_en || (presc < PW'(TICK_CYCLES / 2));

endmodule

// File: tb/tb_clock_time_core.sv
// Scoreboard bench for clock_time_core: directed stimulus pushes expected
// values, a negedge monitor pops and compares against the DUT outputs.
module tb_clock_time_core;

    logic       clk = 1'b0;
    logic       rst, run_en, mode_12h, min_btn, hr_btn;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens;
    logic       pm, sec_pulse, colon;

    clock_time_core #(
        .TICK_CYCLES(10), .DB_CYCLES(3), .RPT_DELAY_CYCLES(20), .RPT_PERIOD_CYCLES(5)
    ) dut (
        .clk(clk), .rst(rst), .run_en(run_en), .mode_12h(mode_12h),
        .min_btn(min_btn), .hr_btn(hr_btn),
        .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
        .hr_ones(hr_ones), .hr_tens(hr_tens), .pm(pm), .sec_pulse(sec_pulse), .colon(colon)
    );

    always #5 clk = ~clk;

    // kind: 0 display time, 1 pulse count, 2 colon, 3 pulse width errors, 4 bench-computed
    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
        logic [31:0] act;
    } chk_t;

    chk_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   pulse_cnt = 0;
    int   width_err = 0;

    initial begin : monitor
        chk_t        c;
        logic [31:0] act;
        logic        prev_pulse;
        prev_pulse = 1'b0;
        forever begin
            @(negedge clk);
            if (sec_pulse) begin
                if (prev_pulse) width_err++;
                pulse_cnt++;
            end
            prev_pulse = sec_pulse;
            while (q.size() > 0) begin
                c = q.pop_front();
                case (c.kind)
                    0:       act = {7'b0, pm, hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones};
                    1:       act = pulse_cnt;
                    2:       act = {31'b0, colon};
                    3:       act = width_err;
                    default: act = c.act;
                endcase
                checks++;
                if (act !== c.exp) begin
                    failures++;
                    $display("FAIL %s: got %0h expected %0h", c.name, act, c.exp);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    function automatic logic [31:0] tv(input int p, input int h, input int m, input int s);
        logic [31:0] r;
        r = {7'b0, p[0], 4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
        return r;
    endfunction

    task automatic push_chk(input string name, input int kind, input logic [31:0] exp,
                            input logic [31:0] act = 32'd0);
        chk_t c;
        c.name = name;
        c.kind = kind;
        c.exp  = exp;
        c.act  = act;
        q.push_back(c);
        @(negedge clk);
        #1;
    endtask

    task automatic tap(input bit is_hr, input int n);
        for (int i = 0; i < n; i++) begin
            if (is_hr) hr_btn = 1'b1; else min_btn = 1'b1;
            repeat (6) @(posedge clk);
            #1;
            hr_btn  = 1'b0;
            min_btn = 1'b0;
            repeat (8) @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin : stimulus
        int base;
        int n;
        rst = 1'b1; run_en = 1'b0; mode_12h = 1'b0; min_btn = 1'b0; hr_btn = 1'b0;
        do_reset();

        // 1: free run for 60 seconds
        push_chk("reset_time", 0, tv(0, 0, 0, 0));
        run_en = 1'b1;
        push_chk("colon_low_half", 2, 32'd1);
        base = pulse_cnt;
        repeat (7) @(posedge clk);
        #1;
        push_chk("colon_high_half", 2, 32'd0);
        repeat (593) @(posedge clk);
        #1;
        run_en = 1'b0;
        push_chk("run_60_ticks", 0, tv(0, 0, 1, 0));
        push_chk("pulse_count_60", 1, base + 60);
        push_chk("pulse_width", 3, 32'd0);

        // 2: set 23:59, run to 23:59:59 and roll over
        tap(1'b1, 23);
        tap(1'b0, 58);
        push_chk("set_23_59", 0, tv(1, 23, 59, 0));
        run_en = 1'b1;
        repeat (590) @(posedge clk);
        #1;
        push_chk("run_to_23_59_59", 0, tv(1, 23, 59, 59));
        repeat (10) @(posedge clk);
        #1;
        run_en = 1'b0;
        push_chk("day_rollover", 0, tv(0, 0, 0, 0));

        // 3: 12h display mapping
        mode_12h = 1'b1;
        push_chk("12h_midnight", 0, tv(0, 12, 0, 0));
        mode_12h = 1'b0;
        push_chk("24h_midnight", 0, tv(0, 0, 0, 0));
        tap(1'b1, 12);
        mode_12h = 1'b1;
        push_chk("12h_noon", 0, tv(1, 12, 0, 0));
        tap(1'b1, 1);
        push_chk("12h_13h", 0, tv(1, 1, 0, 0));
        mode_12h = 1'b0;
        push_chk("24h_13h", 0, tv(1, 13, 0, 0));

        // 4: glitches rejected, held button auto-repeats
        min_btn = 1'b1; @(posedge clk); #1; min_btn = 1'b0;
        repeat (10) @(posedge clk); #1;
        min_btn = 1'b1; repeat (2) @(posedge clk); #1; min_btn = 1'b0;
        repeat (10) @(posedge clk); #1;
        push_chk("glitch_ignored", 0, tv(1, 13, 0, 0));
        min_btn = 1'b1;
        repeat (46) @(posedge clk);
        #1;
        min_btn = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        push_chk("hold_repeat_plus6", 0, tv(1, 13, 6, 0));

        // 5: button events on the tick-wrap cycle
        do_reset();
        tap(1'b1, 10);
        tap(1'b0, 20);
        base = pulse_cnt;
        run_en = 1'b1;
        repeat (374) @(posedge clk);
        #1;
        min_btn = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        run_en = 1'b0;
        min_btn = 1'b0;
        push_chk("min_ev_on_tick", 0, tv(0, 10, 21, 0));
        repeat (8) @(posedge clk);
        #1;
        push_chk("tick_discarded", 1, base + 37);
        tap(1'b1, 13);
        tap(1'b0, 38);
        run_en = 1'b1;
        repeat (590) @(posedge clk);
        #1;
        push_chk("at_23_59_59", 0, tv(1, 23, 59, 59));
        repeat (4) @(posedge clk);
        #1;
        hr_btn = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        run_en = 1'b0;
        hr_btn = 1'b0;
        push_chk("hr_ev_on_wrap", 0, tv(0, 1, 0, 0));
        repeat (8) @(posedge clk);
        #1;

        // 6: reset in the middle of a held button
        do_reset();
        tap(1'b1, 7);
        tap(1'b0, 45);
        run_en = 1'b1;
        repeat (120) @(posedge clk);
        #1;
        push_chk("at_07_45_12", 0, tv(0, 7, 45, 12));
        repeat (5) @(posedge clk);
        #1;
        push_chk("colon_running", 2, 32'd0);
        run_en = 1'b0;
        push_chk("colon_forced", 2, 32'd1);
        min_btn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        push_chk("async_reset", 0, tv(0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n = 0;
        while (n < 20 && min_ones != 4'd1) begin
            @(posedge clk);
            #1;
            n++;
        end
        // Needs the 3-cycle debounce plus synchroniser latency, but no repeat-scale wait.
        push_chk("held_press_latency", 4, 32'd1, {31'b0, (n >= 4 && n <= 8)});
        push_chk("held_press_after_reset", 0, tv(0, 0, 1, 0));
        min_btn = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
